// File: rtl/issue_queue.sv
// Dual-issue pair buffer between fetch and steer, owning the split-issue replay flag.
// Optional same-cycle fetch-to-issue bypass when empty: define QUEUE_BYPASS_EN.
`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif
`ifndef NOP_INSTRUCTION
`define NOP_INSTRUCTION 32'h0000_0013
`endif

module issue_queue #(
  parameter int DEPTH    = 4,
  parameter int PTR_BITS = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   flush,
  input  logic                   fetch_valid,
  input  logic [`INST_WIDTH-1:0] fetch_inst0,
  input  logic [`INST_WIDTH-1:0] fetch_inst1,
  output logic                   fetch_ready,
  input  logic                   pipe_stall,
  input  logic                   steer_stall,
  output logic [`INST_WIDTH-1:0] issue_inst0,
  output logic [`INST_WIDTH-1:0] issue_inst1,
  output logic                   issue_valid,
  output logic                   replay,
  output logic [PTR_BITS:0]      count
);

  localparam logic [PTR_BITS:0] FULL_COUNT = (PTR_BITS+1)'(DEPTH);

  logic [`INST_WIDTH-1:0] mem0 [DEPTH];
  logic [`INST_WIDTH-1:0] mem1 [DEPTH];
  logic [PTR_BITS-1:0]    rd_ptr;
  logic [PTR_BITS-1:0]    wr_ptr;
  logic [PTR_BITS:0]      count_next;
  logic                   empty;
  logic                   push;
  logic                   pop;
  logic                   pop_stored;

  assign empty = (count == '0);

`ifdef QUEUE_BYPASS_EN
  // An empty queue forwards the fetch pair; it is only stored if it fails to pop.
  logic bypass;
  assign bypass      = empty & fetch_valid & ~flush;
  assign issue_valid = ~empty | bypass;
  assign issue_inst0 = !empty ? mem0[rd_ptr] : (bypass ? fetch_inst0 : `NOP_INSTRUCTION);
  assign issue_inst1 = !empty ? mem1[rd_ptr] : (bypass ? fetch_inst1 : `NOP_INSTRUCTION);
  assign pop         = issue_valid & ~pipe_stall & ~steer_stall & ~flush;
  assign push        = fetch_valid & fetch_ready & ~flush & ~(bypass & pop);
`else
  assign issue_valid = ~empty;
  assign issue_inst0 = !empty ? mem0[rd_ptr] : `NOP_INSTRUCTION;
  assign issue_inst1 = !empty ? mem1[rd_ptr] : `NOP_INSTRUCTION;
  assign pop         = issue_valid & ~pipe_stall & ~steer_stall & ~flush;
  assign push        = fetch_valid & fetch_ready & ~flush;
`endif

  assign pop_stored = pop & ~empty;
  assign count_next = count + (PTR_BITS+1)'(push) - (PTR_BITS+1)'(pop_stored);

  always_ff @(posedge clk) begin
    if (push) begin
      mem0[wr_ptr] <= fetch_inst0;
      mem1[wr_ptr] <= fetch_inst1;
    end
  end

  // fetch_ready is registered from count_next so a pop never opens a slot combinationally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      replay      <= 1'b0;
      fetch_ready <= 1'b1;
    end else if (flush) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      replay      <= 1'b0;
      fetch_ready <= 1'b1;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop_stored)
        rd_ptr <= rd_ptr + 1'b1;
      count       <= count_next;
      fetch_ready <= (count_next != FULL_COUNT);
      if (!issue_valid)
        replay <= 1'b0;
      else if (!pipe_stall)
        replay <= steer_stall;
    end
  end

endmodule

// File: tb/tb_issue_queue.sv
// Directed self-checking bench for issue_queue: order, split stall, full, flush, reset, bypass.
`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif
`ifndef NOP_INSTRUCTION
`define NOP_INSTRUCTION 32'h0000_0013
`endif

module tb_issue_queue;

`ifdef QUEUE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif
  localparam logic [31:0] NOP = `NOP_INSTRUCTION;

  logic                   clk = 1'b0;
  logic                   reset_n;
  logic                   flush;
  logic                   fetch_valid;
  logic [`INST_WIDTH-1:0] fetch_inst0;
  logic [`INST_WIDTH-1:0] fetch_inst1;
  logic                   fetch_ready;
  logic                   pipe_stall;
  logic                   steer_stall;
  logic [`INST_WIDTH-1:0] issue_inst0;
  logic [`INST_WIDTH-1:0] issue_inst1;
  logic                   issue_valid;
  logic                   replay;
  logic [2:0]             count;

  int checks_total  = 0;
  int checks_passed = 0;

  issue_queue #(.DEPTH(4), .PTR_BITS(2)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .fetch_valid(fetch_valid), .fetch_inst0(fetch_inst0), .fetch_inst1(fetch_inst1),
    .fetch_ready(fetch_ready), .pipe_stall(pipe_stall), .steer_stall(steer_stall),
    .issue_inst0(issue_inst0), .issue_inst1(issue_inst1), .issue_valid(issue_valid),
    .replay(replay), .count(count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ia(input int k);
    return 32'hA000_0000 | 32'(k);
  endfunction

  function automatic logic [31:0] ib(input int k);
    return 32'hB000_0000 | 32'(k);
  endfunction

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks_total++;
    if (observed === expected)
      checks_passed++;
    else
      $display("FAIL %s: got %0h, expected %0h", tag, observed, expected);
  endtask

  // Inputs change on the falling edge; outputs are sampled 1ns later.
  task automatic apply_stimulus(input logic fv, input int k, input logic ps, input logic ss, input logic fl);
    @(negedge clk);
    fetch_valid = fv;
    fetch_inst0 = ia(k);
    fetch_inst1 = ib(k);
    pipe_stall  = ps;
    steer_stall = ss;
    flush       = fl;
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check_output({tag, " count"}, 32'(count), 0);
    check_output({tag, " issue_valid"}, 32'(issue_valid), 0);
    check_output({tag, " replay"}, 32'(replay), 0);
    check_output({tag, " fetch_ready"}, 32'(fetch_ready), 1);
    check_output({tag, " inst0"}, issue_inst0, NOP);
    check_output({tag, " inst1"}, issue_inst1, NOP);
  endtask

  initial begin
    reset_n = 1'b0; flush = 1'b0; fetch_valid = 1'b0;
    fetch_inst0 = '0; fetch_inst1 = '0; pipe_stall = 1'b0; steer_stall = 1'b0;
    repeat (2) @(negedge clk);
    #1 check_reset_state("reset_init");
    @(negedge clk) reset_n = 1'b1;

    // Order: P0 then P1, second push held by pipe_stall so count walks 1,2,1,0
    apply_stimulus(1, 0, 1, 0, 0);
    check_output("ord_first_valid", 32'(issue_valid), 32'(BYPASS));
    apply_stimulus(1, 1, 1, 0, 0);
    check_output("ord_cnt1", 32'(count), 1);
    check_output("ord_head_p0a", issue_inst0, ia(0));
    check_output("ord_head_p0b", issue_inst1, ib(0));
    apply_stimulus(0, 0, 0, 0, 0);
    check_output("ord_cnt2", 32'(count), 2);
    check_output("ord_p0_again", issue_inst0, ia(0));
    apply_stimulus(0, 0, 0, 0, 0);
    check_output("ord_cnt1b", 32'(count), 1);
    check_output("ord_p1a", issue_inst0, ia(1));
    check_output("ord_p1b", issue_inst1, ib(1));
    apply_stimulus(0, 0, 0, 0, 0);
    check_output("ord_cnt0", 32'(count), 0);
    check_output("ord_empty_valid", 32'(issue_valid), 0);
    check_output("ord_empty_nop", issue_inst0, NOP);

    // Split stall, pipe_stall holding replay, then release
    apply_stimulus(1, 2, 1, 0, 0);
    apply_stimulus(0, 0, 0, 1, 0);
    check_output("split_valid", 32'(issue_valid), 1);
    check_output("split_head", issue_inst0, ia(2));
    check_output("split_replay0", 32'(replay), 0);
    apply_stimulus(0, 0, 1, 1, 0);
    check_output("split_replay1", 32'(replay), 1);
    check_output("split_held_cnt", 32'(count), 1);
    apply_stimulus(0, 0, 0, 0, 0);
    check_output("split_replay_held", 32'(replay), 1);
    check_output("split_cnt_held", 32'(count), 1);
    check_output("split_head_b", issue_inst1, ib(2));
    apply_stimulus(0, 0, 0, 1, 0);
    check_output("split_popped_cnt", 32'(count), 0);
    check_output("split_replay_clr", 32'(replay), 0);
    apply_stimulus(0, 0, 0, 0, 0);
    check_output("empty_steer_ignored", 32'(replay), 0);

    // Full: four pushes under pipe_stall, fifth ignored even while popping
    for (int k = 0; k < 4; k++) begin
      apply_stimulus(1, 10 + k, 1, 0, 0);
      check_output($sformatf("full_fill_cnt%0d", k), 32'(count), 32'(k));
      check_output($sformatf("full_fill_rdy%0d", k), 32'(fetch_ready), 1);
    end
    apply_stimulus(1, 14, 1, 0, 0);
    check_output("full_cnt4", 32'(count), 4);
    check_output("full_rdy0", 32'(fetch_ready), 0);
    check_output("full_head", issue_inst0, ia(10));
    apply_stimulus(1, 14, 0, 0, 0);
    check_output("full_pop_rdy0", 32'(fetch_ready), 0);
    check_output("full_pop_head", issue_inst0, ia(10));
    for (int k = 1; k < 4; k++) begin
      apply_stimulus(0, 0, 0, 0, 0);
      check_output($sformatf("full_drain_cnt%0d", k), 32'(count), 32'(4 - k));
      check_output($sformatf("full_drain_a%0d", k), issue_inst0, ia(10 + k));
      check_output($sformatf("full_drain_b%0d", k), issue_inst1, ib(10 + k));
    end
    check_output("full_rdy_back", 32'(fetch_ready), 1);
    apply_stimulus(0, 0, 0, 0, 0);
    check_output("full_drained", 32'(count), 0);
    check_output("full_drained_valid", 32'(issue_valid), 0);

    // Flush with count=3, replay set and a same-cycle push
    apply_stimulus(1, 20, 1, 0, 0);
    apply_stimulus(1, 21, 1, 0, 0);
    apply_stimulus(1, 22, 1, 0, 0);
    apply_stimulus(0, 0, 0, 1, 0);
    check_output("flush_pre_cnt", 32'(count), 3);
    apply_stimulus(1, 23, 0, 1, 1);
    check_output("flush_pre_replay", 32'(replay), 1);
    apply_stimulus(0, 0, 0, 0, 0);
    check_output("flush_cnt", 32'(count), 0);
    check_output("flush_valid", 32'(issue_valid), 0);
    check_output("flush_replay", 32'(replay), 0);
    check_output("flush_nop", issue_inst0, NOP);
    check_output("flush_rdy", 32'(fetch_ready), 1);
    apply_stimulus(1, 24, 1, 0, 0);
    apply_stimulus(0, 0, 0, 0, 0);
    check_output("flush_after_cnt", 32'(count), 1);
    check_output("flush_after_head", issue_inst0, ia(24));
    apply_stimulus(0, 0, 0, 0, 0);
    check_output("flush_after_empty", 32'(count), 0);

    // Bypass latency (zero with QUEUE_BYPASS_EN, one cycle without)
    apply_stimulus(1, 30, 0, 0, 0);
    check_output("byp_same_valid", 32'(issue_valid), 32'(BYPASS));
    check_output("byp_same_inst", issue_inst0, BYPASS ? ia(30) : NOP);
    apply_stimulus(0, 0, 0, 0, 0);
    check_output("byp_next_cnt", 32'(count), BYPASS ? 0 : 1);
    check_output("byp_next_valid", 32'(issue_valid), BYPASS ? 0 : 1);
    check_output("byp_next_inst", issue_inst1, BYPASS ? NOP : ib(30));
    apply_stimulus(0, 0, 0, 0, 0);
    check_output("byp_drained", 32'(count), 0);

    // Reset asserted mid-traffic with entries and replay pending
    apply_stimulus(1, 40, 1, 0, 0);
    apply_stimulus(1, 41, 1, 0, 0);
    apply_stimulus(0, 0, 0, 1, 0);
    apply_stimulus(0, 0, 1, 1, 0);
    check_output("midrst_pre_replay", 32'(replay), 1);
    check_output("midrst_pre_cnt", 32'(count), 2);
    #1 reset_n = 1'b0;
    #1 check_reset_state("reset_mid");
    apply_stimulus(0, 0, 0, 0, 0);
    reset_n = 1'b1;
    #1;
    check_output("post_rst_cnt", 32'(count), 0);
    check_output("post_rst_valid", 32'(issue_valid), 0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
